// File: rtl/core_pkg.sv
// Shared core definitions: next-PC select encodings and instruction field layout.
package core_pkg;

    typedef enum logic [1:0] {
        PC_SRC_SEQ  = 2'b00,
        PC_SRC_TGT  = 2'b01,
        PC_SRC_JMP  = 2'b10,
        PC_SRC_HOLD = 2'b11
    } pc_src_e;

    localparam int INSTR_W    = 32;
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int JIDX_MSB   = 25;
    localparam int JIDX_LSB   = 0;

    function automatic logic [OPCODE_MSB-OPCODE_LSB:0] get_opcode(input logic [INSTR_W-1:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/return_stack.sv
// Hardware return-address stack: push, pop, replace-top, with sticky overflow/underflow flags.
module return_stack
    import core_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_en,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [ADDR_W-1:0] i_push_data,
    output logic [ADDR_W-1:0] o_top,
    output logic              o_empty,
    output logic              o_full,
    output logic              o_overflow,
    output logic              o_underflow
);

    localparam int IDX_W = $clog2(RAS_DEPTH);
    localparam int SP_W  = IDX_W + 1;

    logic [ADDR_W-1:0] r_mem [RAS_DEPTH];
    logic [SP_W-1:0]   r_sp;
    logic              r_empty;
    logic              r_full;
    logic              r_overflow;
    logic              r_underflow;

    logic [IDX_W-1:0]  w_top_idx;
    logic [SP_W-1:0]   w_sp_nxt;
    logic              w_wr;
    logic [IDX_W-1:0]  w_wr_idx;
    logic              w_ovf_set;
    logic              w_unf_set;

    // At full depth the low index bits wrap to zero, so minus one still lands on the top slot.
    assign w_top_idx = r_sp[IDX_W-1:0] - IDX_W'(1);
    assign o_top     = r_mem[w_top_idx];

    // Next stack pointer, write request and error detection for this cycle.
    always_comb begin
        w_sp_nxt  = r_sp;
        w_wr      = 1'b0;
        w_wr_idx  = r_sp[IDX_W-1:0];
        w_ovf_set = 1'b0;
        w_unf_set = 1'b0;
        if (i_en) begin
            if (i_pop) begin
                if (!r_empty) begin
                    if (i_push) begin
                        w_wr     = 1'b1;
                        w_wr_idx = w_top_idx;
                    end else begin
                        w_sp_nxt = r_sp - SP_W'(1);
                    end
                end else begin
                    w_unf_set = 1'b1;
                    if (i_push) begin
                        w_wr     = 1'b1;
                        w_wr_idx = IDX_W'(0);
                        w_sp_nxt = SP_W'(1);
                    end else begin
                        w_sp_nxt = r_sp;
                    end
                end
            end else if (i_push) begin
                if (r_full) begin
                    w_ovf_set = 1'b1;
                end else begin
                    w_wr     = 1'b1;
                    w_sp_nxt = r_sp + SP_W'(1);
                end
            end else begin
                w_sp_nxt = r_sp;
            end
        end else begin
            w_sp_nxt = r_sp;
        end
    end

    // Stack pointer, status and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sp        <= SP_W'(0);
            r_empty     <= 1'b1;
            r_full      <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_sp        <= w_sp_nxt;
            r_empty     <= (w_sp_nxt == SP_W'(0));
            r_full      <= (w_sp_nxt == SP_W'(RAS_DEPTH));
            r_overflow  <= r_overflow | w_ovf_set;
            r_underflow <= r_underflow | w_unf_set;
        end
    end

    // Entry storage; contents past the pointer are dead, so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[w_wr_idx] <= i_push_data;
        end
    end

    assign o_empty     = r_empty;
    assign o_full      = r_full;
    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, next-PC mux, instruction register and return-address stack.
module fetch_unit
    import core_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                RAS_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_PC  = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               PCWrite,
    input  logic [1:0]         pcSrc,
    input  logic               push,
    input  logic               pop,
    input  logic               halt,
    input  logic [ADDR_W-1:0]  target_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W-1:0]  pc_plus4,
    output logic [INSTR_W-1:0] instruction,
    output logic [5:0]         opcode,
    output logic               ras_empty,
    output logic               ras_full,
    output logic               ras_overflow,
    output logic               ras_underflow
);

    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  r_pc_plus4;
    logic [INSTR_W-1:0] r_instr;

    logic               w_update;
    logic [ADDR_W-1:0]  w_seq_pc;
    logic [ADDR_W-1:0]  w_jmp_pc;
    logic [ADDR_W-1:0]  w_ras_top;
    logic [ADDR_W-1:0]  w_pc_nxt;

    assign w_update = PCWrite & ~halt;
    assign w_seq_pc = r_pc + ADDR_W'(4);
    assign w_jmp_pc = {w_seq_pc[ADDR_W-1:28], imem_rdata[JIDX_MSB:JIDX_LSB], 2'b00};

    return_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .reset       (reset),
        .i_en        (w_update),
        .i_push      (push),
        .i_pop       (pop),
        .i_push_data (w_seq_pc),
        .o_top       (w_ras_top),
        .o_empty     (ras_empty),
        .o_full      (ras_full),
        .o_overflow  (ras_overflow),
        .o_underflow (ras_underflow)
    );

    // Next-PC selection; a return outranks the pcSrc select.
    always_comb begin
        w_pc_nxt = r_pc;
        if (pop) begin
            if (!ras_empty) begin
                w_pc_nxt = w_ras_top;
            end else begin
                w_pc_nxt = r_pc;
            end
        end else begin
            case (pc_src_e'(pcSrc))
                PC_SRC_SEQ:  w_pc_nxt = w_seq_pc;
                PC_SRC_TGT:  w_pc_nxt = target_addr;
                PC_SRC_JMP:  w_pc_nxt = w_jmp_pc;
                PC_SRC_HOLD: w_pc_nxt = r_pc;
                default:     w_pc_nxt = r_pc;
            endcase
        end
    end

    // PC, return-address latch and instruction register advance only on an update cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_pc_plus4 <= RESET_PC;
            r_instr    <= {INSTR_W{1'b0}};
        end else if (w_update) begin
            r_pc       <= w_pc_nxt;
            r_pc_plus4 <= w_seq_pc;
            r_instr    <= imem_rdata;
        end else begin
            r_pc       <= r_pc;
            r_pc_plus4 <= r_pc_plus4;
            r_instr    <= r_instr;
        end
    end

    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign pc_plus4    = r_pc_plus4;
    assign instruction = r_instr;
    assign opcode      = get_opcode(r_instr);

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the multicycle core, directly upstream of the ID-stage control unit. Holds the program counter, drives the instruction-memory address, latches the fetched word into the instruction register, and exposes the opcode field the control unit decodes. It consumes the control unit's `PCWrite`, `pcSrc`, `push` and `pop` outputs and contains the hardware return-address stack used by CALL/RET.

## Interface
- `ADDR_W`, 32: PC and address width.
- `RAS_DEPTH`, 8: return-address-stack entries (power of two, ≥2).
- `RESET_PC`, 32'h0000_0000: PC value after reset.

- `clk`  in  1  core clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; one clock cycle clock is the only clock.
- `PCWrite`  in  1  fetch strobe from the control unit; qualifies every update in this block.
- `pcSrc`  in  2  next-PC select: 00 sequential, 01 target, 10 jump, 11 hold.
- `push`  in  1  CALL: push return address (qualified by `PCWrite`).
- `pop`  in  1  RET: pop return address into PC (qualified by `PCWrite`).
- `halt`  in  1  freezes PC, IR and stack while high.
- `target_addr`  in  ADDR_W  branch/call target computed downstream.
- `imem_rdata`  in  32  instruction memory read data (asynchronous read of `imem_addr`).
- `imem_addr`  out  ADDR_W  equals `pc` (combinational).
- `pc`  out  ADDR_W  current PC.
- `pc_plus4`  out  ADDR_W  PC of the latched instruction + 4.
- `instruction`  out  32  instruction register.
- `opcode`  out  6  `instruction[31:26]`.
- `ras_empty`, `ras_full`  out  1  stack status.
- `ras_overflow`, `ras_underflow`  out  1  sticky error flags, cleared only by reset.

## Operation
- Update cycle = rising edge with `PCWrite`=1 and `halt`=0. No other edge changes any register.
- On an update cycle: `instruction` <= `imem_rdata`; `pc_plus4` <= `pc`+4; PC loads next-PC below.
- Next-PC, priority order:
  - `pop`=1 and stack non-empty: top of stack.
  - `pop`=1 and stack empty: PC unchanged, `ras_underflow` set.
  - `pcSrc`=00: `pc`+4. 01: `target_addr`. 10: {(`pc`+4)[ADDR_W-1:28], `imem_rdata`[25:0], 2'b00}. 11: PC unchanged.
- `push`=1: pushes `pc`+4 (return address of the instruction fetched now); if full, push is dropped, stack unchanged, `ras_overflow` set.
- `push` and `pop` together, non-empty: top entry replaced with `pc`+4, PC loads old top, depth unchanged. Together while empty: push performed, `ras_underflow` set, PC unchanged.
- Stack pointer counts 0..RAS_DEPTH; no wrap-around, overflow never corrupts existing entries.
- Addition is modulo 2^ADDR_W; PC wraps silently from all-ones-minus-3 to 0.
- `push`/`pop` held high across several cycles act only once per update cycle.

## Timing
- Reset values: `pc`=RESET_PC, `pc_plus4`=RESET_PC, `instruction`=0 (so `opcode`=0, decoded as nop), stack pointer 0, `ras_empty`=1, `ras_full`=0, both sticky flags 0.
- Reset dominates `PCWrite`, `halt`, `push`, `pop` in the same cycle; reset mid-program discards the stack.
- Latency: `instruction`/`opcode` valid the cycle after the update edge; new `pc` and `imem_addr` visible the same cycle.
- `ras_empty`/`ras_full`/flags registered; they reflect the update one cycle after the edge.
- `halt` has priority over `PCWrite`; releasing `halt` resumes with no lost or duplicated fetch.

## Structure
- Shared package `core_pkg`: `pcSrc` encodings (PC_SRC_SEQ=2'b00, PC_SRC_TGT=2'b01, PC_SRC_JMP=2'b10, PC_SRC_HOLD=2'b11), opcode field positions [31:26], jump index field [25:0], instruction width 32.
- One sub-module `return_stack` (parameters ADDR_W, RAS_DEPTH): push/pop/replace, top output, empty/full, overflow/underflow detection. PC mux and IR stay in `fetch_unit`.

## Test plan
- Reset, then 3 update cycles with `pcSrc`=00, imem returns 0x2008_0005 → `pc` 0,4,8,12; `opcode`=6'b001000 after first update; `pc_plus4`=4.
- At `pc`=0x40, `pcSrc`=01, `target_addr`=0x100 → `pc`=0x100; with `PCWrite`=0 for 4 cycles → `pc` stays 0x100.
- At `pc`=0x1000_0010, `pcSrc`=10, imem=0x0C00_0040 → `pc`=0x1000_0100.
- CALL at `pc`=0x20 (`push`=1, `pcSrc`=01, target 0x80), then RET (`pop`=1) → `pc`=0x24; `ras_empty` back to 1.
- 9 pushes with RAS_DEPTH=8 → `ras_full`=1 after 8th, `ras_overflow`=1 after 9th; 8 pops return addresses in LIFO order; 9th pop → PC held, `ras_underflow`=1.
- Simultaneous `push`+`pop` with depth 3 → depth stays 3, PC = old top; `reset` asserted with `PCWrite`=1 → `pc`=RESET_PC, flags cleared.
